// File: rtl/render_sequencer_if.sv
// rtl/render_sequencer_if.sv - ASCII controller write port shared by the render sequencer and its sink
interface render_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13
);
    logic              ascii_write_en;
    logic [DATA_W-1:0] ascii_input;
    logic [ADDR_W-1:0] ascii_write_address;

    modport master (
        output ascii_write_en,
        output ascii_input,
        output ascii_write_address
    );

    modport slave (
        input ascii_write_en,
        input ascii_input,
        input ascii_write_address
    );
endinterface

// File: rtl/render_sequencer.sv
// rtl/render_sequencer.sv - sequences NUM_CH view renderers and muxes their ASCII writes
// Optional clear-screen pass before rendering is compiled in with RENDER_SEQ_CLEAR_EN.
module render_sequencer #(
    parameter int NUM_CH         = 3,
    parameter int SEL_W          = 2,
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 13,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int CLEAR_DEPTH    = 4800
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         select,
    output logic [NUM_CH-1:0]        ch_rst_n,
    output logic [NUM_CH-1:0]        ch_start,
    input  logic [NUM_CH-1:0]        ch_done,
    input  logic [NUM_CH-1:0]        ch_write_en,
    input  logic [NUM_CH*DATA_W-1:0] ch_input,
    input  logic [NUM_CH*ADDR_W-1:0] ch_write_address,
    render_sequencer_if.master       ascii,
    output logic [SEL_W-1:0]         active_ch,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [SEL_W:0]   NUM_CH_X = (SEL_W + 1)'(NUM_CH);
    localparam logic [SEL_W:0]   LAST_CH_X = (SEL_W + 1)'(NUM_CH - 1);

    typedef enum logic [2:0] {
        IDLE,
        RESET_CH,
        START_CH,
        WAIT_CH,
        NEXT,
        DONE
`ifdef RENDER_SEQ_CLEAR_EN
        , CLEAR
`endif
    } state_t;

    state_t           state, state_n;
    logic             mode_q;
    logic [TMR_W-1:0] timer;
    logic             accept, advance, set_to, act_done, sel_oor;

`ifdef RENDER_SEQ_CLEAR_EN
    localparam int CLR_W = (CLEAR_DEPTH > 1) ? $clog2(CLEAR_DEPTH) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_DEPTH - 1);
    logic [CLR_W-1:0] clr_cnt;
    logic             oor_q;
`endif

    assign sel_oor = ({1'b0, select} >= NUM_CH_X);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            active_ch   <= '0;
            mode_q      <= 1'b0;
            timer       <= '0;
            timeout_err <= 1'b0;
`ifdef RENDER_SEQ_CLEAR_EN
            clr_cnt     <= '0;
            oor_q       <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (accept) begin
                mode_q      <= mode;
                active_ch   <= mode ? '0 : select;
                timeout_err <= 1'b0;
`ifdef RENDER_SEQ_CLEAR_EN
                clr_cnt     <= '0;
                oor_q       <= !mode && sel_oor;
`endif
            end
            if (advance) begin
                active_ch <= active_ch + 1'b1;
            end
            if (state == RESET_CH) begin
                timer <= '0;
            end else if (state == WAIT_CH) begin
                timer <= timer + 1'b1;
            end
            if (set_to) begin
                timeout_err <= 1'b1;
            end
`ifdef RENDER_SEQ_CLEAR_EN
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
`endif
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        advance = 1'b0;
        set_to  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
`ifdef RENDER_SEQ_CLEAR_EN
                    state_n = CLEAR;
`else
                    state_n = (!mode && sel_oor) ? DONE : RESET_CH;
`endif
                end
            end
`ifdef RENDER_SEQ_CLEAR_EN
            CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    state_n = oor_q ? DONE : RESET_CH;
                end
            end
`endif
            RESET_CH: state_n = START_CH;
            START_CH: state_n = WAIT_CH;
            WAIT_CH: begin
                // A done on the final timer cycle takes priority over the timeout.
                if (act_done) begin
                    state_n = NEXT;
                end else if (TIMEOUT_CYCLES != 0 && timer == TMR_LAST) begin
                    set_to  = 1'b1;
                    state_n = NEXT;
                end
            end
            NEXT: begin
                if (mode_q && ({1'b0, active_ch} < LAST_CH_X)) begin
                    advance = 1'b1;
                    state_n = RESET_CH;
                end else begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Channel fan-out and write mux; only the owning channel is ever routed.
    always_comb begin
        ch_rst_n                  = rst ? '0 : '1;
        ch_start                  = '0;
        act_done                  = 1'b0;
        ascii.ascii_write_en      = 1'b0;
        ascii.ascii_input         = '0;
        ascii.ascii_write_address = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (active_ch == SEL_W'(i)) begin
                act_done = ch_done[i];
                if (!rst && state == RESET_CH) begin
                    ch_rst_n[i] = 1'b0;
                end
                if (state == START_CH || state == WAIT_CH) begin
                    ch_start[i]               = 1'b1;
                    ascii.ascii_write_en      = ch_write_en[i];
                    ascii.ascii_input         = ch_input[i*DATA_W +: DATA_W];
                    ascii.ascii_write_address = ch_write_address[i*ADDR_W +: ADDR_W];
                end
            end
        end
`ifdef RENDER_SEQ_CLEAR_EN
        if (state == CLEAR) begin
            ascii.ascii_write_en      = 1'b1;
            ascii.ascii_input         = DATA_W'(32'h20);
            ascii.ascii_write_address = ADDR_W'(clr_cnt);
        end
`endif
    end

endmodule

// File: tb/tb_render_sequencer.sv
// tb/tb_render_sequencer.sv - directed self-checking bench for render_sequencer
module tb_render_sequencer;

    localparam int NUM_CH = 3;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 13;
`ifdef RENDER_SEQ_CLEAR_EN
    localparam int CLR = 8;
`else
    localparam int CLR = 0;
`endif

    logic                     clk = 1'b0;
    logic                     rst, start, mode;
    logic [SEL_W-1:0]         select;
    logic [NUM_CH-1:0]        ch_rst_n, ch_start, ch_done, ch_write_en;
    logic [NUM_CH*DATA_W-1:0] ch_input;
    logic [NUM_CH*ADDR_W-1:0] ch_write_address;
    logic [SEL_W-1:0]         active_ch;
    logic                     busy, done, timeout_err;

    render_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ascii ();

    render_sequencer #(
        .NUM_CH(NUM_CH), .SEL_W(SEL_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(16), .CLEAR_DEPTH(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .select(select),
        .ch_rst_n(ch_rst_n), .ch_start(ch_start), .ch_done(ch_done),
        .ch_write_en(ch_write_en), .ch_input(ch_input),
        .ch_write_address(ch_write_address), .ascii(ascii.master),
        .active_ch(active_ch), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic m, input logic [SEL_W-1:0] sel);
        mode   = m;
        select = sel;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    int rst_low, other, dn, dn_at, st_cnt, st_edges, en_cnt, bad_owner, bad_addr, bad_data;
    int cnt [NUM_CH];
    int act_log [8];
    int n_act;
    logic [NUM_CH-1:0] prev_start;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; select = '0;
        ch_done = '0; ch_write_en = '0;
        ch_input = {32'h0000_2222, 32'h0000_CAFE, 32'h0000_1111};
        ch_write_address = {13'h0099, 13'h0042, 13'h0011};
        step(); step();
        check_vec("rst_ch_rst_n", ch_rst_n, 3'b000);
        check_vec("rst_ch_start", ch_start, 3'b000);
        check_vec("rst_busy", busy, 0);
        check_vec("rst_done", done, 0);
        check_vec("rst_timeout", timeout_err, 0);
        check_vec("rst_active", active_ch, 0);
        check_vec("rst_ascii", {ascii.ascii_write_en, ascii.ascii_input, ascii.ascii_write_address}, 0);
        rst = 1'b0;
        step();
        check_vec("idle_ch_rst_n", ch_rst_n, 3'b111);

        // Single channel 1, done raised 10 cycles after its start.
        pulse_start(1'b0, 2'd1);
        rst_low = 0; other = 0; dn = 0; dn_at = 0;
        for (int c = 1; c <= 20 + CLR; c++) begin
            if (c == 12 + CLR) ch_done[1] = 1'b1;
            if (c == 1) check_vec("t1_busy", busy, 1);
            if (c == 2 + CLR) check_vec("t1_start", ch_start, 3'b010);
            if (ch_rst_n != 3'b111) begin
                rst_low++;
                check_vec("t1_rst_pat", ch_rst_n, 3'b101);
            end
            if (ch_start[0] || ch_start[2]) other++;
            if (done) begin dn++; dn_at = c; end
            step();
        end
        ch_done = '0;
        check_vec("t1_rst_cycles", rst_low, 1);
        check_vec("t1_other_start", other, 0);
        check_vec("t1_done_count", dn, 1);
        check_vec("t1_done_at", dn_at, 14 + CLR);
        check_vec("t1_timeout", timeout_err, 0);
        check_vec("t1_idle", busy, 0);

        // Sweep all channels, each done 5 cycles after its start; only channel 1 writes.
        ch_write_en = 3'b010;
        for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
        pulse_start(1'b1, 2'd2);
        rst_low = 0; dn = 0; dn_at = 0; st_edges = 0; en_cnt = 0;
        bad_owner = 0; bad_addr = 0; bad_data = 0; n_act = 0; prev_start = '0;
        for (int c = 1; c <= 30 + CLR; c++) begin
            for (int i = 0; i < NUM_CH; i++) if (cnt[i] >= 5) ch_done[i] = 1'b1;
            #1;
            if (c > CLR) begin
                if (n_act == 0 || act_log[n_act-1] != int'(active_ch)) begin
                    if (n_act < 8) act_log[n_act] = int'(active_ch);
                    n_act++;
                end
                if (ascii.ascii_write_en) begin
                    if (active_ch != 2'd1) bad_owner++;
                    else en_cnt++;
                    if (ascii.ascii_write_address != 13'h0042) bad_addr++;
                    if (ascii.ascii_input != 32'h0000_CAFE) bad_data++;
                end
            end
            if (ch_rst_n != 3'b111) rst_low++;
            if (ch_start != 0 && prev_start == 0) st_edges++;
            prev_start = ch_start;
            if (done) begin dn++; dn_at = c; end
            for (int i = 0; i < NUM_CH; i++) begin
                if (!ch_rst_n[i]) begin cnt[i] = 0; ch_done[i] = 1'b0; end
                else if (ch_start[i]) cnt[i]++;
            end
            step();
        end
        ch_done = '0; ch_write_en = '0;
        check_vec("t2_act_count", n_act, 3);
        check_vec("t2_act_seq", {act_log[0][3:0], act_log[1][3:0], act_log[2][3:0]}, 12'h012);
        check_vec("t2_resets", rst_low, 3);
        check_vec("t2_starts", st_edges, 3);
        check_vec("t2_done_count", dn, 1);
        check_vec("t2_done_at", dn_at, 25 + CLR);
        check_vec("t2_wr_owner", bad_owner, 0);
        check_vec("t2_wr_cycles", en_cnt, 6);
        check_vec("t2_wr_addr", bad_addr, 0);
        check_vec("t2_wr_data", bad_data, 0);

        // Channel 2 never finishes; a start pulse mid-pass must be ignored.
        pulse_start(1'b0, 2'd2);
        st_cnt = 0; other = 0; dn = 0; dn_at = 0;
        for (int c = 1; c <= 24 + CLR; c++) begin
            if (c == 5 + CLR) begin start = 1'b1; mode = 1'b1; select = 2'd0; end
            if (c == 6 + CLR) start = 1'b0;
            if (ch_start[2]) st_cnt++;
            if (ch_start[0] || ch_start[1]) other++;
            if (done) begin dn++; dn_at = c; end
            step();
        end
        check_vec("t3_wait_cycles", st_cnt, 17);
        check_vec("t3_other_start", other, 0);
        check_vec("t3_done_count", dn, 1);
        check_vec("t3_done_at", dn_at, 20 + CLR);
        check_vec("t3_timeout", timeout_err, 1);
        for (int c = 0; c < 5; c++) step();
        check_vec("t3_sticky", timeout_err, 1);

        // Stale done on channel 0 is held through RESET and START.
        ch_done = 3'b001;
        pulse_start(1'b0, 2'd0);
        check_vec("t4_to_clear", timeout_err, 0);
        dn = 0; dn_at = 0;
        for (int c = 1; c <= 14 + CLR; c++) begin
            if (c == 3 + CLR) ch_done[0] = 1'b0;
            if (c == 8 + CLR) ch_done[0] = 1'b1;
            if (done) begin dn++; dn_at = c; end
            step();
        end
        ch_done = '0;
        check_vec("t4_done_count", dn, 1);
        check_vec("t4_done_at", dn_at, 10 + CLR);

        // Out-of-range select goes straight to completion.
        pulse_start(1'b0, 2'd3);
        other = 0; dn = 0; dn_at = 0; rst_low = 0;
        for (int c = 1; c <= 6 + CLR; c++) begin
            if (ch_start != 0) other++;
            if (ch_rst_n != 3'b111) rst_low++;
            if (done) begin dn++; dn_at = c; end
            step();
        end
        check_vec("t5_no_start", other, 0);
        check_vec("t5_no_reset", rst_low, 0);
        check_vec("t5_done_at", dn_at, 1 + CLR);
        check_vec("t5_done_count", dn, 1);
        check_vec("t5_timeout", timeout_err, 0);
        check_vec("t5_active", active_ch, 3);

        // Reset in the middle of a WAIT aborts the pass.
        pulse_start(1'b0, 2'd1);
        for (int c = 1; c < 5 + CLR; c++) step();
        check_vec("t5_in_wait", ch_start, 3'b010);
        rst = 1'b1;
        step();
        check_vec("t5_rst_busy", busy, 0);
        check_vec("t5_rst_done", done, 0);
        check_vec("t5_rst_start", ch_start, 3'b000);
        check_vec("t5_rst_rst_n", ch_rst_n, 3'b000);
        check_vec("t5_rst_active", active_ch, 0);
        check_vec("t5_rst_ascii", ascii.ascii_write_en, 0);
        rst = 1'b0;
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) dn++;
            step();
        end
        check_vec("t5_abort_quiet", dn, 0);
        check_vec("t5_rst_n_after", ch_rst_n, 3'b111);

`ifdef RENDER_SEQ_CLEAR_EN
        // Clear pass writes spaces to 0..7, then renders channel 1.
        pulse_start(1'b0, 2'd1);
        bad_addr = 0; bad_data = 0; en_cnt = 0; dn = 0; rst_low = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 3) start = 1'b1;
            if (c == 4) start = 1'b0;
            if (c == 12) ch_done[1] = 1'b1;
            if (c <= 8) begin
                if (ascii.ascii_write_en) en_cnt++;
                if (ascii.ascii_input != 32'h20) bad_data++;
                if (ascii.ascii_write_address != 13'(c - 1)) bad_addr++;
            end
            if (c == 9) check_vec("t6_reset_ch", ch_rst_n, 3'b101);
            if (done) dn++;
            step();
        end
        ch_done = '0;
        check_vec("t6_clr_writes", en_cnt, 8);
        check_vec("t6_clr_data", bad_data, 0);
        check_vec("t6_clr_addr", bad_addr, 0);
        check_vec("t6_done_count", dn, 1);
        check_vec("t6_idle", busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
